// File: rtl/sixteen_bit_serial_skip_subtractor_if.sv
// sixteen_bit_serial_skip_subtractor_if: start/operand/result bundle for the serial skip subtractor
//   inp_start, inp_A, inp_B, inp_bin             : request and operands (master -> slave)
//   out_D, out_bout, out_busy, out_done,
//   out_skip_count                               : results and status (slave -> master)
interface sixteen_bit_serial_skip_subtractor_if;
    logic        inp_start;
    logic [15:0] inp_A;
    logic [15:0] inp_B;
    logic        inp_bin;
    logic [15:0] out_D;
    logic        out_bout;
    logic        out_busy;
    logic        out_done;
    logic [2:0]  out_skip_count;
    modport master (
        output inp_start, inp_A, inp_B, inp_bin,
        input  out_D, out_bout, out_busy, out_done, out_skip_count
    );
    modport slave (
        input  inp_start, inp_A, inp_B, inp_bin,
        output out_D, out_bout, out_busy, out_done, out_skip_count
    );
endinterface

// File: rtl/sixteen_bit_serial_skip_subtractor.sv
// sixteen_bit_serial_skip_subtractor: A - B - bin, one 4-bit carry-skip group per cycle
//   inp_clk    : clock, rising edge
//   inp_rst_n  : asynchronous active-low reset
//   bus        : slave side of the start/operand/result bundle
module sixteen_bit_serial_skip_subtractor (
    input logic                                  inp_clk,
    input logic                                  inp_rst_n,
    sixteen_bit_serial_skip_subtractor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state, state_nxt;
    logic [15:0] a_q, b_q;
    logic [11:0] acc_q;
    logic        carry_q;
    logic [1:0]  grp_q;
    logic [2:0]  skip_q;
    logic        accept, last;
    logic [3:0]  a_nib, nb_nib, prop;
    logic [4:0]  sum;
    logic        skip, cout;
    assign accept = bus.inp_start && state != CALC;
    assign last   = state == CALC && grp_q == 2'd3;
    always_comb begin
        state_nxt = state;
        state_nxt = accept ? CALC : state == CALC ? (last ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end
    // Operands shift right so the active group always sits in the low nibble.
    assign a_nib  = a_q[3:0];
    assign nb_nib = ~b_q[3:0];
    assign prop   = a_nib ^ nb_nib;
    assign sum    = {1'b0, a_nib} + {1'b0, nb_nib} + {4'b0, carry_q};
    assign skip   = &prop;
    // A fully propagating group passes its carry-in straight through.
    assign cout   = skip ? carry_q : sum[4];
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            a_q                <= '0;
            b_q                <= '0;
            acc_q              <= '0;
            carry_q            <= 1'b0;
            grp_q              <= '0;
            skip_q             <= '0;
            bus.out_D          <= '0;
            bus.out_bout       <= 1'b0;
            bus.out_skip_count <= '0;
        end else if (accept) begin
            a_q     <= bus.inp_A;
            b_q     <= bus.inp_B;
            acc_q   <= '0;
            carry_q <= ~bus.inp_bin;
            grp_q   <= '0;
            skip_q  <= '0;
        end else if (state == CALC) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            acc_q   <= {sum[3:0], acc_q[11:4]};
            carry_q <= cout;
            grp_q   <= grp_q + 2'd1;
            skip_q  <= skip_q + {2'b0, skip};
            if (last) begin
                bus.out_D          <= {sum[3:0], acc_q};
                bus.out_bout       <= ~cout;
                bus.out_skip_count <= skip_q + {2'b0, skip};
            end
        end
    end
    assign bus.out_busy = state == CALC;
    assign bus.out_done = state == DONE;
endmodule

// File: tb/tb_sixteen_bit_serial_skip_subtractor.sv
// tb_sixteen_bit_serial_skip_subtractor: directed and randomized checks of the serial skip subtractor
module tb_sixteen_bit_serial_skip_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    sixteen_bit_serial_skip_subtractor_if bus ();
    sixteen_bit_serial_skip_subtractor dut (
        .inp_clk   (clk),
        .inp_rst_n (rst_n),
        .bus       (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [2:0] skip_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [2:0]  n;
        x = a ^ ~b;
        n = 3'd0;
        for (int i = 0; i < 4; i++) if (x[i*4 +: 4] == 4'hF) n = n + 3'd1;
        return n;
    endfunction
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
        bus.inp_start = 1'b1;
        bus.inp_A     = a;
        bus.inp_B     = b;
        bus.inp_bin   = c;
    endtask
    task automatic scramble();
        bus.inp_start = 1'b0;
        bus.inp_A     = ~bus.inp_A;
        bus.inp_B     = ~bus.inp_B;
        bus.inp_bin   = ~bus.inp_bin;
    endtask
    task automatic wait_done(input bit pulse, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            bus.inp_start = pulse && n == 1;
        end while (!bus.out_done && n < 8);
        check("done_seen", bus.out_done, 1);
    endtask
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input bit pulse,
                          input logic [15:0] d_exp, input logic bout_exp, input logic [2:0] skip_exp);
        int n;
        @(negedge clk);
        drive(a, b, c);
        @(posedge clk);
        #1;
        scramble();
        check("busy_rise", bus.out_busy, 1);
        check("done_early", bus.out_done, 0);
        wait_done(pulse, n);
        check("latency", n, 4);
        check("D", bus.out_D, d_exp);
        check("bout", bus.out_bout, bout_exp);
        check("skip", bus.out_skip_count, skip_exp);
        check("busy_fall", bus.out_busy, 0);
        @(posedge clk);
        #1;
        check("done_width", bus.out_done, 0);
        if (pulse) begin
            n = 0;
            repeat (6) begin
                @(posedge clk);
                #1;
                if (bus.out_done) n++;
            end
            check("extra_done", n, 0);
        end
    endtask
    initial begin
        logic [15:0] a, b;
        logic        c;
        logic [16:0] diff;
        bus.inp_start = 1'b0;
        bus.inp_A     = 16'h0;
        bus.inp_B     = 16'h0;
        bus.inp_bin   = 1'b0;
        #12;
        check("rst_D", bus.out_D, 0);
        check("rst_bout", bus.out_bout, 0);
        check("rst_busy", bus.out_busy, 0);
        check("rst_done", bus.out_done, 0);
        check("rst_skip", bus.out_skip_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd4);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 3'd3);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 3'd4);
        run_op(16'hA5F0, 16'h1234, 1'b1, 1'b1, 16'h93BB, 1'b0, 3'd0);
        @(negedge clk);
        drive(16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        scramble();
        wait_done(1'b0, lat);
        check("b2b_first_D", bus.out_D, 16'h00FE);
        drive(16'h0010, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        scramble();
        check("b2b_busy", bus.out_busy, 1);
        check("b2b_done_low", bus.out_done, 0);
        check("b2b_hold0", bus.out_D, 16'h00FE);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("b2b_hold", bus.out_D, 16'h00FE);
            check("b2b_done_mid", bus.out_done, 0);
        end
        @(posedge clk);
        #1;
        check("b2b_done", bus.out_done, 1);
        check("b2b_D", bus.out_D, 16'h000F);
        check("b2b_bout", bus.out_bout, 0);
        check("b2b_skip", bus.out_skip_count, 2);
        check("b2b_busy_fall", bus.out_busy, 0);
        @(negedge clk);
        drive(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        scramble();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_D", bus.out_D, 0);
        check("abort_bout", bus.out_bout, 0);
        check("abort_busy", bus.out_busy, 0);
        check("abort_done", bus.out_done, 0);
        check("abort_skip", bus.out_skip_count, 0);
        drive(16'h8000, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        check("start_in_rst", bus.out_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        scramble();
        check("post_rst_busy", bus.out_busy, 1);
        wait_done(1'b0, lat);
        check("post_rst_lat", lat, 4);
        check("post_rst_D", bus.out_D, 16'h7FFF);
        check("post_rst_bout", bus.out_bout, 0);
        check("post_rst_skip", bus.out_skip_count, 2);
        @(posedge clk);
        #1;
        for (int n = 0; n < 10000; n++) begin
            a    = 16'($urandom);
            b    = 16'($urandom);
            c    = 1'($urandom_range(0, 1));
            diff = {1'b0, a} - {1'b0, b} - {16'b0, c};
            drive(a, b, c);
            @(posedge clk);
            #1;
            scramble();
            wait_done(1'b0, lat);
            check("rnd_lat", lat, 4);
            check("rnd_D", bus.out_D, diff[15:0]);
            check("rnd_bout", bus.out_bout, diff[16]);
            check("rnd_skip", bus.out_skip_count, skip_model(a, b));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sixteen_bit_serial_skip_subtractor.md
SIXTEEN_BIT_SERIAL_SKIP_SUBTRACTOR -- requirements
Module: sixteen_bit_serial_skip_subtractor

Interface
REQ-001: The block SHALL have one clock and an asynchronous, active-low reset, both listed first among the ports below.
REQ-002: inp_clk  input  1  single clock; all state updates on its rising edge.
REQ-003: inp_rst_n  input  1  asynchronous active-low reset.
REQ-004: inp_start  input  1  request pulse; sampled on rising edge.
REQ-005: inp_A  input  16  minuend; sampled only on an accepted start.
REQ-006: inp_B  input  16  subtrahend; sampled only on an accepted start.
REQ-007: inp_bin  input  1  borrow-in; sampled only on an accepted start.
REQ-008: out_D  output  16  difference, A - B - bin, modulo 2^16.
REQ-009: out_bout  output  1  borrow-out; 1 when A < B + bin as unsigned values.
REQ-010: out_busy  output  1  high while a subtraction is in progress.
REQ-011: out_done  output  1  one-cycle completion strobe.
REQ-012: out_skip_count  output  3  number of nibble groups, 0 to 4, whose carry was skipped.

Function
REQ-013: The block SHALL compute A + ~B + ~bin. It processes one 4-bit carry-skip group per cycle, starting with group 0 (bits 3:0) and ending with group 3.
REQ-014: Group propagate SHALL be p[i] = A[i] ^ ~B[i]. A group is "skipped" when all four of its p bits are 1. In that case the group carry-out SHALL equal the group carry-in, not the ripple result.
REQ-015: The state machine SHALL have three states: IDLE, CALC and DONE.
- IDLE: start=1 moves to CALC.
- CALC: the group index runs 0..3; after group 3 the state moves to DONE.
- DONE: lasts one cycle, then returns to IDLE, or moves directly to CALC if start=1.
REQ-016: inp_start SHALL be accepted only in IDLE or DONE. Acceptance latches A, B and bin, clears the internal nibble accumulator, carry = ~bin, and clears the skip counter.
REQ-017: inp_start SHALL be ignored while in CALC, with no effect on the operation in flight.
REQ-018: Latency: out_done SHALL rise on the 4th rising edge after the accepting edge and stay high for exactly one cycle.
REQ-019: out_busy SHALL rise on the accepting edge and fall on the same edge on which out_done rises.
REQ-020: out_D, out_bout and out_skip_count SHALL update only on the edge on which out_done rises. They hold their values until the next completion or reset; no partial results are visible.
REQ-021: out_bout SHALL be the inverse of the final carry out of group 3.
REQ-022: If start is accepted in DONE, the previous results SHALL remain on the outputs until the new operation completes.
REQ-023: Operand changes on inp_A, inp_B or inp_bin after acceptance SHALL have no effect on the result.

Reset
REQ-024: Asserting inp_rst_n low SHALL, immediately and regardless of the clock, force:
- state = IDLE
- out_D = 0x0000
- out_bout = 0
- out_busy = 0
- out_done = 0
- out_skip_count = 0
REQ-025: Reset asserted during CALC SHALL abort the operation. No out_done SHALL follow, and the first start after reset release SHALL be processed normally.
REQ-026: inp_start high during the cycle in which reset is released SHALL be honoured only if it is sampled on a rising edge while reset is deasserted.

Verification
REQ-027: A=0x1234, B=0x1234, bin=0 -> after 4 edges: D=0x0000, bout=0, skip_count=4, done high for 1 cycle.
REQ-028: A=0x0000, B=0x0001, bin=0 -> D=0xFFFF, bout=1; A=0x0000, B=0x0000, bin=1 -> D=0xFFFF, bout=1.
REQ-029: A=0xA5F0, B=0x1234, bin=1 -> D=0x93BB, bout=0. In the same test, pulse start during CALC -> ignored, one done only.
REQ-030: Back-to-back operations: start held high through DONE with new operands (0x0010-0x0001) -> busy re-asserts, out_D=0x000F appears 4 edges later, and the prior result holds until then.
REQ-031: Reset pulsed at cycle 2 of CALC -> all outputs 0 immediately and no done. The next start with A=0x8000, B=0x0001, bin=0 yields D=0x7FFF, bout=0.
REQ-032: Random regression of at least 10,000 operands against the model D=(A-B-bin) mod 2^16, with skip_count checked against a per-nibble all-ones count of A ^ ~B.
